// File: rtl/rfft_drain.sv
// Streams the 256 RFFT results from four 64-word banks, natural or bit-reversed order.
// First word 3 cycles after start; 2-entry skid FIFO, reads stall when it would overflow.
module rfft_drain #(
  parameter int WIDTH  = 32,
  parameter int NPTS   = 256,
  parameter bit BITREV = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic [5:0]       addr_a,
  output logic [5:0]       addr_b,
  input  logic [WIDTH-1:0] ram_out0,
  input  logic [WIDTH-1:0] ram_out1,
  input  logic [WIDTH-1:0] ram_out2,
  input  logic [WIDTH-1:0] ram_out3,
  output logic [WIDTH-1:0] data_out,
  output logic [7:0]       data_idx,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0] LAST_K = 8'(NPTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       k;
  logic [7:0]       samp;
  logic             issue;
  logic             pop;
  logic [2:0]       slots_used;
  logic             drain_end;
  logic             rd_vld;
  logic [1:0]       rd_bank;
  logic [7:0]       rd_idx;
  logic [WIDTH-1:0] rd_dat;
  logic [WIDTH-1:0] fifo_dat [2];
  logic [7:0]       fifo_idx [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign samp   = BITREV ? bitrev8(k) : k;
  assign addr_a = (state == RUN) ? samp[5:0] : 6'd0;
  assign addr_b = (state == RUN) ? samp[5:0] : 6'd0;

  assign valid = (occ != 2'd0);
  assign pop   = valid && ready;
  // A read issued now lands in the FIFO next cycle, so count it against the 2 slots.
  assign slots_used = {1'b0, occ} + {2'b00, rd_vld} - {2'b00, pop};
  assign issue      = (state == RUN) && (slots_used < 3'd2);
  assign drain_end  = (state == FLUSH) && !rd_vld &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

  assign busy     = (state != IDLE);
  assign data_out = valid ? fifo_dat[rd_ptr] : '0;
  assign data_idx = valid ? fifo_idx[rd_ptr] : 8'd0;
  assign last     = valid && (data_idx == LAST_K);

  always_comb begin
    rd_dat = ram_out0;
    case (rd_bank)
      2'd0: rd_dat = ram_out0;
      2'd1: rd_dat = ram_out1;
      2'd2: rd_dat = ram_out2;
      2'd3: rd_dat = ram_out3;
      default: rd_dat = ram_out0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && (k == LAST_K)) state_nxt = FLUSH;
      FLUSH:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      k       <= 8'd0;
      rd_vld  <= 1'b0;
      rd_bank <= 2'd0;
      rd_idx  <= 8'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
      done    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_dat[i] <= '0;
        fifo_idx[i] <= 8'd0;
      end
    end else begin
      done <= drain_end;
      if ((state == IDLE) && start) k <= 8'd0;
      else if (issue)               k <= k + 8'd1;
      // Bank id and position travel alongside the one-cycle RAM read.
      rd_vld <= issue;
      if (issue) begin
        rd_bank <= samp[7:6];
        rd_idx  <= k;
      end
      if (rd_vld) begin
        fifo_dat[wr_ptr] <= rd_dat;
        fifo_idx[wr_ptr] <= rd_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rfft_drain.sv
// Drives a natural-order and a bit-reversed drain side by side from one sample memory.
module tb_rfft_drain;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] mem [256];

  logic [5:0]  addr_a0, addr_b0, addr_a1, addr_b1;
  logic [31:0] r00, r01, r02, r03, r10, r11, r12, r13;
  logic [31:0] d0, d1;
  logic [7:0]  idx0, idx1;
  logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

  int total = 0;
  int bad   = 0;
  int exp_k = 0;
  int nwords = 0;
  int ndone = 0;
  bit rnd_ready = 1'b0;

  always #5 Clk = ~Clk;

  rfft_drain #(.WIDTH(32), .NPTS(256), .BITREV(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .addr_a(addr_a0), .addr_b(addr_b0),
    .ram_out0(r00), .ram_out1(r01), .ram_out2(r02), .ram_out3(r03),
    .data_out(d0), .data_idx(idx0), .valid(valid0), .ready(ready),
    .last(last0), .busy(busy0), .done(done0)
  );

  rfft_drain #(.WIDTH(32), .NPTS(256), .BITREV(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .addr_a(addr_a1), .addr_b(addr_b1),
    .ram_out0(r10), .ram_out1(r11), .ram_out2(r12), .ram_out3(r13),
    .data_out(d1), .data_idx(idx1), .valid(valid1), .ready(ready),
    .last(last1), .busy(busy1), .done(done1)
  );

  // Registered bank RAMs: sample s lives at mem[s], bank s[7:6], address s[5:0].
  always @(posedge Clk) begin
    r00 <= mem[{2'd0, addr_a0}];
    r01 <= mem[{2'd1, addr_a0}];
    r02 <= mem[{2'd2, addr_b0}];
    r03 <= mem[{2'd3, addr_b0}];
    r10 <= mem[{2'd0, addr_a1}];
    r11 <= mem[{2'd1, addr_a1}];
    r12 <= mem[{2'd2, addr_b1}];
    r13 <= mem[{2'd3, addr_b1}];
  end

  function automatic int brev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rst_vals();
    chk("rst_addr_a0", addr_a0, 0);  chk("rst_addr_b0", addr_b0, 0);
    chk("rst_data0", d0, 0);         chk("rst_idx0", idx0, 0);
    chk("rst_valid0", valid0, 0);    chk("rst_last0", last0, 0);
    chk("rst_busy0", busy0, 0);      chk("rst_done0", done0, 0);
    chk("rst_addr_a1", addr_a1, 0);  chk("rst_valid1", valid1, 0);
    chk("rst_busy1", busy1, 0);      chk("rst_done1", done1, 0);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      tick();
      if (done0) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  // Scoreboard: every accepted word must be the next position in order.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      exp_k  = 0;
      nwords = 0;
    end else begin
      if (valid0 && ready) begin
        chk("idx0", idx0, exp_k);
        chk("data0", d0, mem[exp_k]);
        chk("valid1", valid1, 1);
        chk("idx1", idx1, exp_k);
        chk("data1", d1, mem[brev(exp_k)]);
        chk("last0", last0, exp_k == 255);
        exp_k  = (exp_k + 1) % 256;
        nwords = nwords + 1;
      end
      if (done0) begin
        chk("words_per_drain", nwords, 256);
        chk("done1", done1, 1);
        nwords = 0;
        ndone  = ndone + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 256; s++) mem[s] = 32'(s);
    repeat (3) tick();
    rst_vals();
    Reset_n = 1'b1;
    repeat (2) tick();

    // Full-rate drain with exact cycle timing, then restart in the done cycle.
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_busy", busy0, 1);
    chk("c1_addr_a", addr_a0, 0);
    chk("c1_addr_b", addr_b0, 0);
    tick();
    chk("c2_valid", valid0, 0);
    tick();
    for (int k = 0; k < 256; k++) begin
      chk("run_valid", valid0, 1);
      chk("run_idx", idx0, k);
      if (k == 1)   chk("brev_pos1", d1, 128);
      if (k == 2)   chk("brev_pos2", d1, 64);
      if (k == 254) chk("no_early_last", last0, 0);
      if (k == 255) begin
        chk("last_at_255", last0, 1);
        chk("brev_pos255", d1, 255);
      end
      tick();
    end
    chk("done_c259", done0, 1);
    chk("busy_c259", busy0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy0, 1);
    wait_done(600);
    repeat (3) tick();

    // Stall from cycle 5 for 20 cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    ready = 1'b0;
    for (int c = 5; c < 25; c++) begin
      chk("stall_valid", valid0, 1);
      chk("stall_idx", idx0, 2);
      chk("stall_addr0", addr_a0, 4);
      chk("stall_addr1", addr_a1, 32);
      tick();
    end
    ready = 1'b1;
    for (int c = 25; c < 35; c++) begin
      chk("resume_valid", valid0, 1);
      chk("resume_idx", idx0, c - 23);
      tick();
    end
    wait_done(600);
    repeat (3) tick();

    // Random data and random backpressure.
    for (int s = 0; s < 256; s++) mem[s] = $urandom;
    rnd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4000);
    rnd_ready = 1'b0;
    ready = 1'b1;
    repeat (3) tick();

    // Reset mid-drain at cycle 100, then a fresh drain.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    rst_vals();
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_done", done0, 0);
      chk("post_rst_valid", valid0, 0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("rst_restart_valid", valid0, 1);
    chk("rst_restart_idx", idx0, 0);
    wait_done(600);
    repeat (3) tick();

    // Start pulsed again mid-drain must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(600);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("after_drain_busy", busy0, 0);
      chk("after_drain_valid", valid0, 0);
    end

    chk("done_count", ndone, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
